// File: rtl/id_stage_param.sv
// Decode stage: register file with forwarding, load-use/branch hazard stall, branch resolution and ID/EX register.
// Optional branch statistics counters are built when ID_STAGE_BRANCH_STATS_EN is defined.
module id_stage_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32,
  parameter int CTRL_W     = 16,
  parameter int STAT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_hold,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [15:0]           i_imm,
  input  logic [PC_W-1:0]       i_pc_plus_4,
  input  logic                  i_is_branch,
  input  logic [2:0]            i_br_type,
  input  logic [CTRL_W-1:0]     i_ctrl,
  input  logic                  i_flush,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_mem_reg_write,
  input  logic                  i_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [DATA_W-1:0]     i_mem_alu_result,
  output logic                  o_stall,
  output logic                  o_pc_src,
  output logic [PC_W-1:0]       o_branch_target,
  output logic                  o_idex_valid,
  output logic [DATA_W-1:0]     o_idex_data_1,
  output logic [DATA_W-1:0]     o_idex_data_2,
  output logic [DATA_W-1:0]     o_idex_imm,
  output logic [REG_ADDR_W-1:0] o_idex_rs,
  output logic [REG_ADDR_W-1:0] o_idex_rt,
  output logic [REG_ADDR_W-1:0] o_idex_rd,
  output logic [CTRL_W-1:0]     o_idex_ctrl,
  output logic [STAT_W-1:0]     o_br_count,
  output logic [STAT_W-1:0]     o_br_taken_count
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam logic signed [DATA_W-1:0] ZERO = '0;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     rf_val,
    input logic                  mem_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [DATA_W-1:0]     mem_val,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [DATA_W-1:0]     wb_val
  );
    if (addr == '0)                 return '0;
    else if (mem_en && mem_rd == addr) return mem_val;
    else if (wb_en && wb_rd == addr)   return wb_val;
    else                               return rf_val;
  endfunction

  logic [DATA_W-1:0] r_rf [NREG];

  logic                     w_mem_fwd;
  logic signed [DATA_W-1:0] w_op_a;
  logic signed [DATA_W-1:0] w_op_b;
  logic                     w_ex_haz;
  logic                     w_mem_haz;
  logic                     w_cond;
  logic                     w_bubble;
  logic signed [15:0]       w_imm_s;
  logic [PC_W-1:0]          w_imm_pc;
  logic [DATA_W-1:0]        w_imm_data;

  assign w_mem_fwd = i_mem_reg_write & ~i_mem_mem_read;
  assign w_op_a = fwd_sel(i_rs, r_rf[i_rs], w_mem_fwd, i_mem_rd, i_mem_alu_result,
                          i_wb_we, i_wb_rd, i_wb_data);
  assign w_op_b = fwd_sel(i_rt, r_rf[i_rt], w_mem_fwd, i_mem_rd, i_mem_alu_result,
                          i_wb_we, i_wb_rd, i_wb_data);

  // Loads in EX always stall; ALU results in EX also stall a branch since it resolves here.
  assign w_ex_haz  = i_ex_reg_write && (i_ex_rd != '0) &&
                     ((i_ex_rd == i_rs) || (i_ex_rd == i_rt)) &&
                     (i_ex_mem_read || i_is_branch);
  assign w_mem_haz = i_is_branch && i_mem_mem_read && (i_mem_rd != '0) &&
                     ((i_mem_rd == i_rs) || (i_mem_rd == i_rt));
  assign o_stall   = i_valid & (w_ex_haz | w_mem_haz);

  always_comb begin
    w_cond = 1'b0;
    case (i_br_type)
      3'd0:    w_cond = (w_op_a == w_op_b);
      3'd1:    w_cond = (w_op_a != w_op_b);
      3'd2:    w_cond = (w_op_a <= ZERO);
      3'd3:    w_cond = (w_op_a >  ZERO);
      3'd4:    w_cond = (w_op_a <  ZERO);
      3'd5:    w_cond = (w_op_a >= ZERO);
      default: w_cond = 1'b0;
    endcase
  end

  assign o_pc_src = i_valid & i_is_branch & ~o_stall & ~i_hold & w_cond;

  assign w_imm_s         = i_imm;
  assign w_imm_pc        = PC_W'(w_imm_s);
  assign w_imm_data      = DATA_W'(w_imm_s);
  assign o_branch_target = i_pc_plus_4 + (w_imm_pc << 2);

  assign w_bubble = i_flush | o_stall | ~i_valid;

  // Register file: x0 is never written, so it stays at its reset value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (i_wb_we && !i_hold && (i_wb_rd != '0)) begin
      r_rf[i_wb_rd] <= i_wb_data;
    end
  end

  // ---- ID/EX boundary (p1) ----
  logic                  r_vld_p1;
  logic [DATA_W-1:0]     r_data_1_p1;
  logic [DATA_W-1:0]     r_data_2_p1;
  logic [DATA_W-1:0]     r_imm_p1;
  logic [REG_ADDR_W-1:0] r_rs_p1;
  logic [REG_ADDR_W-1:0] r_rt_p1;
  logic [REG_ADDR_W-1:0] r_rd_p1;
  logic [CTRL_W-1:0]     r_ctrl_p1;

  always_ff @(posedge i_clk) begin
    if (i_reset || (!i_hold && w_bubble)) begin
      r_vld_p1    <= 1'b0;
      r_data_1_p1 <= '0;
      r_data_2_p1 <= '0;
      r_imm_p1    <= '0;
      r_rs_p1     <= '0;
      r_rt_p1     <= '0;
      r_rd_p1     <= '0;
      r_ctrl_p1   <= '0;
    end else if (!i_hold) begin
      r_vld_p1    <= 1'b1;
      r_data_1_p1 <= w_op_a;
      r_data_2_p1 <= w_op_b;
      r_imm_p1    <= w_imm_data;
      r_rs_p1     <= i_rs;
      r_rt_p1     <= i_rt;
      r_rd_p1     <= i_rd;
      r_ctrl_p1   <= i_ctrl;
    end
  end

  assign o_idex_valid  = r_vld_p1;
  assign o_idex_data_1 = r_data_1_p1;
  assign o_idex_data_2 = r_data_2_p1;
  assign o_idex_imm    = r_imm_p1;
  assign o_idex_rs     = r_rs_p1;
  assign o_idex_rt     = r_rt_p1;
  assign o_idex_rd     = r_rd_p1;
  assign o_idex_ctrl   = r_ctrl_p1;

`ifdef ID_STAGE_BRANCH_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              w_br_resolved;
  logic [STAT_W-1:0] r_br_cnt_p1;
  logic [STAT_W-1:0] r_br_tkn_p1;

  assign w_br_resolved = i_valid & i_is_branch & ~o_stall & ~i_hold;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_br_cnt_p1 <= '0;
      r_br_tkn_p1 <= '0;
    end else begin
      if (w_br_resolved) r_br_cnt_p1 <= sat_inc(r_br_cnt_p1);
      if (o_pc_src)      r_br_tkn_p1 <= sat_inc(r_br_tkn_p1);
    end
  end

  assign o_br_count       = r_br_cnt_p1;
  assign o_br_taken_count = r_br_tkn_p1;
`else
  assign o_br_count       = '0;
  assign o_br_taken_count = '0;
`endif

endmodule

// File: tb/tb_id_stage_param.sv
// Scoreboard bench for id_stage_param: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage_param;

  localparam int SW = 4;
`ifdef ID_STAGE_BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct packed {
    bit        reset, hold, valid;
    bit [4:0]  rs, rt, rd;
    bit [15:0] imm;
    bit [31:0] pc4;
    bit        is_branch;
    bit [2:0]  br_type;
    bit [15:0] ctrl;
    bit        flush;
    bit        wb_we;
    bit [4:0]  wb_rd;
    bit [31:0] wb_data;
    bit        ex_rw, ex_mr;
    bit [4:0]  ex_rd;
    bit        mem_rw, mem_mr;
    bit [4:0]  mem_rd;
    bit [31:0] mem_res;
  } stim_t;

  typedef struct {
    int        due;
    bit        stall, pc_src;
    bit [31:0] tgt;
  } comb_exp_t;

  typedef struct {
    int        due;
    bit        vld;
    bit [31:0] d1, d2, imm;
    bit [4:0]  rs, rt, rd;
    bit [15:0] ctrl;
    bit [SW-1:0] brc, btc;
  } reg_exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset, i_hold, i_valid;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [15:0] i_imm;
  logic [31:0] i_pc_plus_4;
  logic        i_is_branch;
  logic [2:0]  i_br_type;
  logic [15:0] i_ctrl;
  logic        i_flush, i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_ex_reg_write, i_ex_mem_read;
  logic [4:0]  i_ex_rd;
  logic        i_mem_reg_write, i_mem_mem_read;
  logic [4:0]  i_mem_rd;
  logic [31:0] i_mem_alu_result;
  logic        o_stall, o_pc_src;
  logic [31:0] o_branch_target;
  logic        o_idex_valid;
  logic [31:0] o_idex_data_1, o_idex_data_2, o_idex_imm;
  logic [4:0]  o_idex_rs, o_idex_rt, o_idex_rd;
  logic [15:0] o_idex_ctrl;
  logic [SW-1:0] o_br_count, o_br_taken_count;

  id_stage_param #(.STAT_W(SW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_hold(i_hold), .i_valid(i_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_imm(i_imm), .i_pc_plus_4(i_pc_plus_4),
    .i_is_branch(i_is_branch), .i_br_type(i_br_type), .i_ctrl(i_ctrl), .i_flush(i_flush),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_read(i_mem_mem_read), .i_mem_rd(i_mem_rd),
    .i_mem_alu_result(i_mem_alu_result),
    .o_stall(o_stall), .o_pc_src(o_pc_src), .o_branch_target(o_branch_target),
    .o_idex_valid(o_idex_valid), .o_idex_data_1(o_idex_data_1), .o_idex_data_2(o_idex_data_2),
    .o_idex_imm(o_idex_imm), .o_idex_rs(o_idex_rs), .o_idex_rt(o_idex_rt), .o_idex_rd(o_idex_rd),
    .o_idex_ctrl(o_idex_ctrl), .o_br_count(o_br_count), .o_br_taken_count(o_br_taken_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  comb_exp_t q_c[$];
  reg_exp_t  q_r[$];

  // Behavioural model state
  bit [31:0]   m_rf[32];
  reg_exp_t    m_id;
  bit [SW-1:0] m_brc, m_btc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit [31:0] opnd(input stim_t s, input bit [4:0] ad);
    if (ad == 0) return 32'h0;
    if (s.mem_rw && !s.mem_mr && s.mem_rd == ad) return s.mem_res;
    if (s.wb_we && s.wb_rd == ad) return s.wb_data;
    return m_rf[ad];
  endfunction

  task automatic drive(input stim_t s);
    bit [31:0] a, b, se;
    int sa, sb;
    bit haz_a, haz_b, stall, cond, pc_src, resolved;
    comb_exp_t ce;
    reg_exp_t  re;
    i_reset = s.reset; i_hold = s.hold; i_valid = s.valid;
    i_rs = s.rs; i_rt = s.rt; i_rd = s.rd; i_imm = s.imm; i_pc_plus_4 = s.pc4;
    i_is_branch = s.is_branch; i_br_type = s.br_type; i_ctrl = s.ctrl; i_flush = s.flush;
    i_wb_we = s.wb_we; i_wb_rd = s.wb_rd; i_wb_data = s.wb_data;
    i_ex_reg_write = s.ex_rw; i_ex_mem_read = s.ex_mr; i_ex_rd = s.ex_rd;
    i_mem_reg_write = s.mem_rw; i_mem_mem_read = s.mem_mr; i_mem_rd = s.mem_rd;
    i_mem_alu_result = s.mem_res;

    a = opnd(s, s.rs);
    b = opnd(s, s.rt);
    sa = int'(a);
    sb = int'(b);
    haz_a = s.ex_rw && s.ex_rd != 0 && (s.ex_rd == s.rs || s.ex_rd == s.rt) && (s.ex_mr || s.is_branch);
    haz_b = s.is_branch && s.mem_mr && s.mem_rd != 0 && (s.mem_rd == s.rs || s.mem_rd == s.rt);
    stall = s.valid && (haz_a || haz_b);
    case (s.br_type)
      3'd0: cond = (sa == sb);
      3'd1: cond = (sa != sb);
      3'd2: cond = (sa <= 0);
      3'd3: cond = (sa > 0);
      3'd4: cond = (sa < 0);
      3'd5: cond = (sa >= 0);
      default: cond = 1'b0;
    endcase
    resolved = s.valid && s.is_branch && !stall && !s.hold;
    pc_src = resolved && cond;
    se = {{16{s.imm[15]}}, s.imm};

    ce.due = cyc; ce.stall = stall; ce.pc_src = pc_src; ce.tgt = s.pc4 + se * 4;
    q_c.push_back(ce);

    if (s.reset) begin
      m_id = '{default: 0};
      foreach (m_rf[i]) m_rf[i] = 32'h0;
      m_brc = '0; m_btc = '0;
    end else begin
      if (!s.hold) begin
        if (s.flush || stall || !s.valid) m_id = '{default: 0};
        else begin
          m_id.vld = 1'b1; m_id.d1 = a; m_id.d2 = b; m_id.imm = se;
          m_id.rs = s.rs; m_id.rt = s.rt; m_id.rd = s.rd; m_id.ctrl = s.ctrl;
        end
        if (s.wb_we && s.wb_rd != 0) m_rf[s.wb_rd] = s.wb_data;
      end
      if (STATS_EN && resolved && m_brc != {SW{1'b1}}) m_brc = m_brc + 1'b1;
      if (STATS_EN && pc_src && m_btc != {SW{1'b1}}) m_btc = m_btc + 1'b1;
    end
    re = m_id;
    re.due = cyc + 1; re.brc = m_brc; re.btc = m_btc;
    q_r.push_back(re);
    @(posedge i_clk);
    #1;
  endtask

  // Combinational outputs are checked mid-cycle while inputs are stable
  always @(negedge i_clk) begin
    if (q_c.size() > 0 && q_c[0].due == cyc) begin
      comb_exp_t e;
      e = q_c.pop_front();
      chk("stall", 64'(o_stall), 64'(e.stall));
      chk("pc_src", 64'(o_pc_src), 64'(e.pc_src));
      chk("branch_target", 64'(o_branch_target), 64'(e.tgt));
    end
  end

  always @(posedge i_clk) begin
    #2;
    if (q_r.size() > 0 && q_r[0].due == cyc) begin
      reg_exp_t e;
      e = q_r.pop_front();
      chk("idex_valid", 64'(o_idex_valid), 64'(e.vld));
      chk("idex_data_1", 64'(o_idex_data_1), 64'(e.d1));
      chk("idex_data_2", 64'(o_idex_data_2), 64'(e.d2));
      chk("idex_imm", 64'(o_idex_imm), 64'(e.imm));
      chk("idex_rs", 64'(o_idex_rs), 64'(e.rs));
      chk("idex_rt", 64'(o_idex_rt), 64'(e.rt));
      chk("idex_rd", 64'(o_idex_rd), 64'(e.rd));
      chk("idex_ctrl", 64'(o_idex_ctrl), 64'(e.ctrl));
      chk("br_count", 64'(o_br_count), 64'(e.brc));
      chk("br_taken_count", 64'(o_br_taken_count), 64'(e.btc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit [31:0] r;
    s = '0;
    i_reset = 1'b1; i_hold = 1'b0; i_valid = 1'b0; i_rs = '0; i_rt = '0; i_rd = '0;
    i_imm = '0; i_pc_plus_4 = '0; i_is_branch = 1'b0; i_br_type = '0; i_ctrl = '0;
    i_flush = 1'b0; i_wb_we = 1'b0; i_wb_rd = '0; i_wb_data = '0; i_ex_reg_write = 1'b0;
    i_ex_mem_read = 1'b0; i_ex_rd = '0; i_mem_reg_write = 1'b0; i_mem_mem_read = 1'b0;
    i_mem_rd = '0; i_mem_alu_result = '0;
    m_id = '{default: 0}; m_brc = '0; m_btc = '0;
    @(posedge i_clk); #1;

    s = '0; s.reset = 1'b1; drive(s); drive(s);

    // WB x5 = 0x10, then BEQ (not taken) and BNE (taken, target 0x110)
    s = '0; s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'h10; drive(s);
    s = '0; s.valid = 1'b1; s.is_branch = 1'b1; s.br_type = 3'd0; s.rs = 5'd5; s.rt = 5'd0;
    s.imm = 16'h0004; s.pc4 = 32'h100; s.ctrl = 16'h0011; drive(s);
    s.br_type = 3'd1; drive(s);

    // Load-use: load to x3 in EX stalls, then in MEM a non-branch proceeds
    s = '0; s.valid = 1'b1; s.rs = 5'd3; s.rt = 5'd1; s.rd = 5'd4; s.ctrl = 16'h0022;
    s.ex_rw = 1'b1; s.ex_mr = 1'b1; s.ex_rd = 5'd3; drive(s);
    s.ex_rw = 1'b0; s.ex_mr = 1'b0; s.ex_rd = 5'd0;
    s.mem_rw = 1'b1; s.mem_mr = 1'b1; s.mem_rd = 5'd3; drive(s);

    // MEM forwarding of a negative value into BLTZ, negative wrapping offset
    s = '0; s.valid = 1'b1; s.is_branch = 1'b1; s.br_type = 3'd4; s.rs = 5'd7;
    s.mem_rw = 1'b1; s.mem_rd = 5'd7; s.mem_res = 32'hFFFF_FFFF;
    s.imm = 16'h8000; s.pc4 = 32'h100; s.ctrl = 16'h0033; drive(s);

    // Writes to x0 are discarded, including through WB forwarding
    s = '0; s.valid = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.wb_we = 1'b1; s.wb_rd = 5'd0;
    s.wb_data = 32'hDEAD_BEEF; drive(s);
    s.wb_we = 1'b0; drive(s);

    // Hold for 3 cycles with changing inputs, then read x9, then reset under hold
    s = '0; s.valid = 1'b1; s.rs = 5'd5; s.rt = 5'd2; s.rd = 5'd6; s.ctrl = 16'hABCD;
    s.imm = 16'h1234; drive(s);
    for (int k = 0; k < 3; k++) begin
      s = '0; s.hold = 1'b1; s.valid = 1'b1; s.is_branch = 1'b1; s.br_type = 3'd0;
      s.rs = 5'd0; s.rt = 5'd0; s.rd = 5'(k + 1); s.ctrl = 16'(k + 16'h100);
      s.wb_we = 1'b1; s.wb_rd = 5'd9; s.wb_data = 32'h1234 + 32'(k); drive(s);
    end
    s = '0; s.valid = 1'b1; s.rs = 5'd9; s.rt = 5'd5; drive(s);
    s.hold = 1'b1; s.reset = 1'b1; drive(s);

    // 20 taken branches drive the 4-bit counters into saturation
    for (int k = 0; k < 20; k++) begin
      s = '0; s.valid = 1'b1; s.is_branch = 1'b1; s.br_type = 3'd0;
      s.pc4 = 32'h200 + 32'(4 * k); s.imm = 16'(k); drive(s);
    end

    // Randomized traffic with a narrow register range to provoke hazards
    for (int k = 0; k < 400; k++) begin
      s = '0;
      s.reset = ($urandom_range(0, 49) == 0);
      s.hold = ($urandom_range(0, 9) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 31));
      r = $urandom; s.imm = r[15:0]; s.ctrl = r[31:16];
      s.pc4 = $urandom;
      s.is_branch = ($urandom_range(0, 1) == 1);
      s.br_type = 3'($urandom_range(0, 7));
      s.flush = ($urandom_range(0, 9) == 0);
      s.wb_we = ($urandom_range(0, 1) == 1);
      s.wb_rd = 5'($urandom_range(0, 7));
      r = $urandom; s.wb_data = ($urandom_range(0, 3) == 0) ? 32'h0 : r;
      s.ex_rw = ($urandom_range(0, 1) == 1); s.ex_mr = ($urandom_range(0, 2) == 0);
      s.ex_rd = 5'($urandom_range(0, 7));
      s.mem_rw = ($urandom_range(0, 1) == 1); s.mem_mr = ($urandom_range(0, 2) == 0);
      s.mem_rd = 5'($urandom_range(0, 7));
      r = $urandom; s.mem_res = ($urandom_range(0, 1) == 0) ? r : 32'($signed(r[3:0]));
      drive(s);
    end

    s = '0; drive(s);
    repeat (2) @(posedge i_clk);
    #3;
    n_chk++;
    if (q_c.size() != 0 || q_r.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q_c.size(), q_r.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_param.md
ID_STAGE_PARAM -- requirements
Module: id_stage_param

Interface
REQ-001 The block SHALL have parameters: DATA_W, 32, datapath width; REG_ADDR_W, 5, register address width (2**REG_ADDR_W registers); PC_W, 32, PC width; CTRL_W, 16, pass-through control bundle width; STAT_W, 16, statistics counter width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, listed as name, direction, width, meaning:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous active-high reset
- i_hold  in  1  freezes all state (debug)
- i_valid  in  1  IF/ID holds a valid instruction
- i_rs, i_rt, i_rd  in  REG_ADDR_W  source and destination fields
- i_imm  in  16  immediate / branch offset
- i_pc_plus_4  in  PC_W  PC of instruction + 4
- i_is_branch  in  1  instruction is a conditional branch
- i_br_type  in  3  branch condition select
- i_ctrl  in  CTRL_W  decoded control bundle
- i_flush  in  1  force bubble into ID/EX
- i_wb_we, i_wb_rd, i_wb_data  in  1/REG_ADDR_W/DATA_W  writeback port
- i_ex_reg_write, i_ex_mem_read, i_ex_rd  in  1/1/REG_ADDR_W  instruction in EX
- i_mem_reg_write, i_mem_mem_read, i_mem_rd, i_mem_alu_result  in  1/1/REG_ADDR_W/DATA_W  instruction in MEM
- o_stall  out  1  hold PC and IF/ID
- o_pc_src  out  1  branch taken
- o_branch_target  out  PC_W  branch target address
- o_idex_valid, o_idex_data_1, o_idex_data_2, o_idex_imm  out  1/DATA_W/DATA_W/DATA_W  registered ID/EX fields
- o_idex_rs, o_idex_rt, o_idex_rd, o_idex_ctrl  out  REG_ADDR_W x3/CTRL_W  registered ID/EX fields
- o_br_count, o_br_taken_count  out  STAT_W  branch statistics

Function
REQ-004 The register file SHALL write i_wb_data to i_wb_rd on the rising edge when i_wb_we=1 and i_hold=0; register 0 SHALL always read 0 and ignore writes.
REQ-005 Operand selection for rs and rt, each independently, SHALL use this priority: address 0 gives 0; otherwise a MEM match (i_mem_reg_write=1, i_mem_mem_read=0, i_mem_rd equals the address) gives i_mem_alu_result; otherwise a same-cycle WB match gives i_wb_data; otherwise the register file value.
REQ-006 o_stall SHALL be combinational and equal i_valid AND (A OR B), where:
- A: i_ex_reg_write=1, i_ex_rd!=0, i_ex_rd matches rs or rt, and (i_ex_mem_read=1 or i_is_branch=1).
- B: i_is_branch=1, i_mem_mem_read=1, i_mem_rd!=0, and i_mem_rd matches rs or rt.
REQ-007 The branch condition SHALL be selected by i_br_type, with a and b the selected rs and rt operands and comparisons signed:
- 0: a==b; 1: a!=b; 2: a<=0; 3: a>0; 4: a<0; 5: a>=0.
- 6 and 7: never taken.
REQ-008 o_pc_src SHALL equal i_valid & i_is_branch & !o_stall & !i_hold & condition, and is combinational.
REQ-009 o_branch_target SHALL equal i_pc_plus_4 + (sign_extend(i_imm) << 2), truncated to PC_W, wrapping modulo 2**PC_W.
REQ-010 o_idex_imm SHALL be the capture of i_imm sign-extended to DATA_W.
REQ-011 The ID/EX register SHALL update on every rising edge with latency 1, using this priority:
- i_reset: clear.
- i_hold: keep all fields.
- i_flush, o_stall or !i_valid: load a bubble (valid=0, ctrl=0, all other fields 0).
- otherwise: capture the selected operands and the inputs.
REQ-012 Simultaneous i_flush and o_stall SHALL produce one bubble.
REQ-013 A WB write to a register being read in the same cycle SHALL be visible both in the captured operands and in the branch comparison.

Reset
REQ-014 On i_reset=1 at a rising edge, all registers SHALL clear to 0, including the register file, o_idex_* and the counters; i_reset SHALL override i_hold.
REQ-015 Reset asserted mid-stall SHALL leave o_idex_valid=0 on the next cycle; o_stall and o_pc_src stay combinational functions of the inputs.

Configuration
REQ-016 The macro ID_STAGE_BRANCH_STATS_EN SHALL control the branch statistics counters:
- Defined: o_br_count increments on each resolved branch (i_valid & i_is_branch & !o_stall & !i_hold); o_br_taken_count increments when o_pc_src=1; both saturate at all-ones.
- Undefined: both outputs are tied to 0 and no counter logic is present.

Verification
REQ-017 The bench SHALL cover: write x5=0x0000_0010 via WB, then BEQ rs=5, rt=0 with i_imm=0x0004 and i_pc_plus_4=0x100 -> o_pc_src=0; BNE in the same setup -> o_pc_src=1 and o_branch_target=0x110.
REQ-018 The bench SHALL cover: EX holds a load to x3 (i_ex_mem_read=1), ID reads rs=3 -> o_stall=1 and o_idex_valid=0 next cycle; after the load advances to MEM with a non-branch in ID -> o_stall=0 and the instruction is captured.
REQ-019 The bench SHALL cover: i_mem_alu_result=0xFFFF_FFFF for rd=7 and BLTZ on rs=7 -> o_pc_src=1 and the captured o_idex_data_1=0xFFFF_FFFF; an i_imm of 0x8000 gives a negative target that wraps.
REQ-020 The bench SHALL cover: i_wb_we=1 with rd=0 and data 0xDEAD_BEEF -> reading rs=0 yields 0 in the same cycle and afterwards.
REQ-021 The bench SHALL cover: i_hold=1 for 3 cycles with changing inputs -> o_idex_* unchanged, no register file write and o_pc_src=0; i_reset asserted during hold -> all outputs 0.
REQ-022 The bench SHALL cover, with ID_STAGE_BRANCH_STATS_EN and STAT_W=4: 20 resolved taken branches -> o_br_count=o_br_taken_count=15 (saturated).
